// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 4-stage 8-bit pipeline. Owns the program
//   counter and an instruction ROM. The ROM is read combinationally at the
//   current pc. One instruction per cycle is registered into the IF/ID
//   boundary. The decode stage can redirect fetch with pc_src/branch_target.
//   A redirect squashes the slot that would have been fetched from the old pc.
//
//   Update priority on each rising edge: rst > pc_src > stall > normal fetch.
//
// Parameters
//   PC_W          PC width; ROM depth is 2**PC_W words
//   INSTR_W       instruction width
//   RESET_PC      pc value loaded on reset
//   NOP_INSTR     value driven on instr whenever instr_valid = 0
//   INIT_FILE     name of the ROM image
//   USE_INIT_FILE 1 = ROM held in a memory array filled at elaboration;
//                 0 = ROM computed combinationally from the address
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-high reset
//   stall          in   hold pc and all IF/ID outputs this cycle
//   pc_src         in   redirect request from decode (taken branch)
//   branch_target  in   absolute redirect address, valid when pc_src = 1
//   instr          out  registered instruction (IF/ID)
//   instr_valid    out  1 = instr is a real instruction, 0 = bubble
//   pc_out         out  address that instr was fetched from
//   pc             out  current fetch address (next instruction to be read)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                 PC_W          = 6,
  parameter int                 INSTR_W       = 8,
  parameter logic [PC_W-1:0]    RESET_PC      = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR     = '0,
  parameter                     INIT_FILE     = "imem.hex",
  parameter bit                 USE_INIT_FILE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               pc_src,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc
);

  localparam int ROM_DEPTH = 2 ** PC_W;

  // Built-in ROM image: a fixed function of the address. Every word is
  // distinct across the default 64-entry space and never equals 8'h00, so a
  // real instruction cannot be confused with a bubble.
  function automatic logic [INSTR_W-1:0] default_word(input logic [PC_W-1:0] addr);
    int unsigned v;
    v = 32'(addr) * 32'd29 + 32'd7;
    return v[INSTR_W-1:0];
  endfunction

  // Combinational ROM read at the current fetch address.
  logic [INSTR_W-1:0] rom_data;

  generate
    if (USE_INIT_FILE) begin : g_file_rom
      // NOTE: ROM storage is never reset. Its contents are set at
      // elaboration, and only the pipeline registers below take rst.
      logic [INSTR_W-1:0] mem [0:ROM_DEPTH-1];

      initial begin
        for (int a = 0; a < ROM_DEPTH; a++) mem[a] = default_word(PC_W'(a));
      end

      assign rom_data = mem[pc];
    end else begin : g_default_rom
      // NOTE: a combinational block assigns its output on every path. Here
      // that is a single unconditional assignment, so no latch can be inferred.
      always_comb begin
        rom_data = default_word(pc);
      end
    end
  endgenerate

  // The PC and IF/ID registers live in one block so the priority order
  // (rst > pc_src > stall > normal) reads top to bottom.
  // NOTE: state is updated with non-blocking assignments. Every right-hand
  // side therefore sees the pre-edge values. For example, pc_out <= pc
  // captures the address that rom_data was read from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      pc_out      <= '0;
    end else if (pc_src) begin
      // A taken branch resolved in decode. The instruction fetched at the old
      // pc is wrong-path, so a bubble goes out instead. pc_out keeps its value.
      // The redirect wins over stall.
      pc          <= branch_target;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      instr       <= rom_data;
      instr_valid <= 1'b1;
      pc_out      <= pc;
      pc          <= pc + PC_W'(1);  // wraps modulo 2**PC_W
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A behavioural model tracks the fetch
//   address and the slot presented at IF/ID using plain integer arithmetic
//   over an array image of the ROM. One compare process checks every output
//   on each falling edge. Directed scenarios pin the model with hand-computed
//   literals, and a randomized phase follows them. That phase includes
//   asynchronous resets that arrive in the middle of a cycle.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 8;
  localparam int DEPTH   = 64;

  logic               clk;
  logic               rst;
  logic               stall;
  logic               pc_src;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [PC_W-1:0]    pc_out;
  logic [PC_W-1:0]    pc;

  fetch_stage #(
    .PC_W          (PC_W),
    .INSTR_W       (INSTR_W),
    .RESET_PC      (6'd0),
    .NOP_INSTR     (8'h00),
    .INIT_FILE     ("imem.hex"),
    .USE_INIT_FILE (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .pc            (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   rom_img  : image of the default ROM (word = (29*addr + 7) mod 256)
  //   m_fetch  : address the next instruction will be fetched from
  //   m_slot_* : what the IF/ID boundary currently presents
  // ---------------------------------------------------------------------------
  int rom_img [DEPTH];
  int m_fetch;
  int m_slot_word;
  int m_slot_valid;
  int m_slot_addr;

  initial begin
    for (int a = 0; a < DEPTH; a++) rom_img[a] = (a * 29 + 7) % 256;
  end

  task automatic model_reset();
    m_fetch      = 0;
    m_slot_word  = 0;
    m_slot_valid = 0;
    m_slot_addr  = 0;
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (!rst) begin
      if (pc_src) begin
        // Redirect: bubble out, fetch resumes at the target.
        m_fetch      = int'(branch_target);
        m_slot_word  = 0;
        m_slot_valid = 0;
      end else if (!stall) begin
        m_slot_word  = rom_img[m_fetch];
        m_slot_valid = 1;
        m_slot_addr  = m_fetch;
        m_fetch      = (m_fetch + 1) % DEPTH;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge once checking is enabled.
  // ---------------------------------------------------------------------------
  bit check_en = 1'b0;

  always @(negedge clk) begin
    if (check_en) begin
      check("pc",          32'(pc),          32'(m_fetch));
      check("instr",       32'(instr),       32'(m_slot_word));
      check("instr_valid", 32'(instr_valid), 32'(m_slot_valid));
      check("pc_out",      32'(pc_out),      32'(m_slot_addr));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs are driven at a falling edge and held across the
  // next rising edge. Each helper returns at the following falling edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic s, input logic p, input logic [PC_W-1:0] t);
    stall         = s;
    pc_src        = p;
    branch_target = t;
    @(negedge clk);
  endtask

  // Raise rst between clock edges and check the cleared state before any edge
  // can occur. Release it at the next falling edge.
  task automatic async_reset_pulse(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, " async pc"},          32'(pc),          32'd0);
    check({tag, " async instr"},       32'(instr),       32'h00);
    check({tag, " async instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, " async pc_out"},      32'(pc_out),      32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    stall         = 1'b0;
    pc_src        = 1'b0;
    branch_target = '0;

    repeat (2) @(negedge clk);
    rst      = 1'b0;
    check_en = 1'b1;

    // Reset state after release, before any edge.
    check("reset pc",          32'(pc),          32'd0);
    check("reset instr_valid", 32'(instr_valid), 32'd0);
    check("reset instr",       32'(instr),       32'h00);

    // Run a little, then reset in mid-run.
    repeat (4) cyc(1'b0, 1'b0, '0);
    async_reset_pulse("mid-run");

    // First three fetches after release.
    cyc(1'b0, 1'b0, '0);
    check("t1 pc_out0", 32'(pc_out), 32'd0);
    check("t1 instr0",  32'(instr),  32'd7);
    check("t1 pc1",     32'(pc),     32'd1);
    cyc(1'b0, 1'b0, '0);
    check("t1 pc_out1", 32'(pc_out), 32'd1);
    check("t1 instr1",  32'(instr),  32'd36);
    cyc(1'b0, 1'b0, '0);
    check("t1 pc_out2", 32'(pc_out), 32'd2);
    check("t1 instr2",  32'(instr),  32'd65);
    check("t1 pc3",     32'(pc),     32'd3);

    // Stall at pc=5 for two cycles.
    repeat (2) cyc(1'b0, 1'b0, '0);
    repeat (2) cyc(1'b1, 1'b0, '0);
    check("t2 stall pc",     32'(pc),          32'd5);
    check("t2 stall pc_out", 32'(pc_out),      32'd4);
    check("t2 stall instr",  32'(instr),       32'd123);
    check("t2 stall valid",  32'(instr_valid), 32'd1);
    cyc(1'b0, 1'b0, '0);
    check("t2 resume instr",  32'(instr),  32'd152);
    check("t2 resume pc_out", 32'(pc_out), 32'd5);

    // Redirect at pc=7 to 20.
    cyc(1'b0, 1'b0, '0);
    check("t3 pc7", 32'(pc), 32'd7);
    cyc(1'b0, 1'b1, 6'd20);
    check("t3 bubble valid", 32'(instr_valid), 32'd0);
    check("t3 bubble instr", 32'(instr),       32'h00);
    check("t3 bubble pc",    32'(pc),          32'd20);
    check("t3 bubble pc_out hold", 32'(pc_out), 32'd6);
    cyc(1'b0, 1'b0, '0);
    check("t3 target instr",  32'(instr),  32'd75);
    check("t3 target pc_out", 32'(pc_out), 32'd20);
    check("t3 target pc",     32'(pc),     32'd21);

    // Redirect and stall in the same cycle: the redirect wins.
    cyc(1'b1, 1'b1, 6'd3);
    check("t4 pc",    32'(pc),          32'd3);
    check("t4 valid", 32'(instr_valid), 32'd0);
    check("t4 instr", 32'(instr),       32'h00);

    // Wrap from 62.
    cyc(1'b0, 1'b1, 6'd62);
    cyc(1'b0, 1'b0, '0);
    check("t5 pc_out62", 32'(pc_out), 32'd62);
    check("t5 pc63",     32'(pc),     32'd63);
    check("t5 instr62",  32'(instr),  32'd13);
    cyc(1'b0, 1'b0, '0);
    check("t5 pc_out63", 32'(pc_out), 32'd63);
    check("t5 pc0",      32'(pc),     32'd0);
    check("t5 instr63",  32'(instr),  32'd42);
    cyc(1'b0, 1'b0, '0);
    check("t5 pc_out0",  32'(pc_out),      32'd0);
    check("t5 pc1",      32'(pc),          32'd1);
    check("t5 valid",    32'(instr_valid), 32'd1);

    // Back-to-back redirects: each produces a bubble, and the last target wins.
    cyc(1'b0, 1'b1, 6'd10);
    check("t6 bubble1 valid", 32'(instr_valid), 32'd0);
    check("t6 pc10",          32'(pc),          32'd10);
    cyc(1'b0, 1'b1, 6'd40);
    check("t6 bubble2 valid", 32'(instr_valid), 32'd0);
    check("t6 pc40",          32'(pc),          32'd40);
    cyc(1'b0, 1'b0, '0);
    check("t6 instr40",  32'(instr),  32'd143);
    check("t6 pc_out40", 32'(pc_out), 32'd40);
    check("t6 pc41",     32'(pc),     32'd41);

    // Randomized traffic, including occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        stall         = 1'($urandom_range(0, 1));
        pc_src        = 1'($urandom_range(0, 1));
        branch_target = PC_W'($urandom);
        async_reset_pulse("random");
      end else begin
        cyc(1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 6) == 0),
            PC_W'($urandom));
      end
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
